// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths and the opcode map used by fetch and control.
package cpu_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 8;
    localparam int unsigned OPC_W   = 4;

    typedef enum logic [OPC_W-1:0] {
        OPC_HALT = 4'h0,
        OPC_LDI  = 4'h1,
        OPC_ADD  = 4'h2,
        OPC_SUB  = 4'h3,
        OPC_AND  = 4'h4,
        OPC_OR   = 4'h5,
        OPC_XOR  = 4'h6,
        OPC_LD   = 4'h7,
        OPC_ST   = 4'h8,
        OPC_JMP  = 4'h9,
        OPC_JZ   = 4'hA,
        OPC_JNZ  = 4'hB,
        OPC_OUT  = 4'hC,
        OPC_NOP  = 4'hF
    } opcode_e;

    function automatic logic is_halt(input logic [OPC_W-1:0] opc);
        return opc == OPC_W'(OPC_HALT);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction buffer: synchronous FIFO of (instruction, fetch address) pairs with flush.
module instr_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PC_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [DATA_W-1:0]            push_data_i,
    input  logic [PC_W-1:0]              push_pc_i,
    input  logic                         pop_i,
    output logic                         valid_o,
    output logic [DATA_W-1:0]            data_o,
    output logic [PC_W-1:0]              pc_o,
    output logic [$clog2(DEPTH):0]       count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PC_W-1:0]   pc_q   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                data_q[wr_ptr_q] <= push_data_i;
                pc_q[wr_ptr_q]   <= push_pc_i;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign valid_o = (count_q != '0);
    assign data_o  = data_q[rd_ptr_q];
    assign pc_o    = pc_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: credit-based issue to program memory, response capture, HALT and redirect handling.
module instruction_fetch_unit #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ADDR_W  = cpu_pkg::ADDR_W,
    parameter int unsigned INSTR_W = cpu_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               halted
);
    import cpu_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic              halted_q, halted_d;

    logic [CNT_W-1:0]  count;
    logic              fifo_valid;
    logic              issue;
    logic              capture;
    logic              pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= '0;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            halted_q      <= halted_d;
        end
    end

    // Occupancy credit counts the in-flight response, so a push never meets a full buffer.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = 1'b0;
        halted_d      = halted_q;

        issue   = !halted_q && !redirect
                  && ((OCC_W'(count) + OCC_W'(inflight_q)) < OCC_W'(DEPTH));
        capture = inflight_q && !halted_q && !redirect;
        pop     = fifo_valid && instr_ready && !redirect;

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            halted_d   = 1'b0;
        end else begin
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
            end
            if (capture && is_halt(rom_data[7:4])) begin
                halted_d = 1'b1;
            end
        end
    end

    instr_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (INSTR_W),
        .PC_W   (ADDR_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (redirect),
        .push_i      (capture),
        .push_data_i (rom_data),
        .push_pc_i   (inflight_pc_q),
        .pop_i       (pop),
        .valid_o     (fifo_valid),
        .data_o      (instr),
        .pc_o        (instr_pc),
        .count_o     (count)
    );

    assign rom_addr    = fetch_pc_q;
    assign instr_valid = fifo_valid;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a program-order stream model.
module tb_instruction_fetch_unit;

    logic       clk;
    logic       reset;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic       halted;

    logic [7:0] rom [256];

    int         vectors;
    int         miscompares;

    // stream model: next program-order address expected at the buffer head
    logic [7:0] exp_pc;
    logic       halt_seen;
    int         accepts;
    int         stall_cnt;
    logic [7:0] acc_pcs[$];

    instruction_fetch_unit #(
        .DEPTH   (4),
        .ADDR_W  (8),
        .INSTR_W (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // program memory: one-cycle registered read
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] plain_word();
        logic [3:0] opc;
        logic [3:0] opr;
        opc = 4'($urandom_range(15, 1));
        opr = 4'($urandom);
        return {opc, opr};
    endfunction

    task automatic fill_rom(input int halt_pct);
        for (int i = 0; i < 256; i++) begin
            if (int'($urandom_range(99, 0)) < halt_pct)
                rom[i] = {4'h0, 4'($urandom)};
            else
                rom[i] = plain_word();
        end
    endtask

    // Judge the cycle about to be clocked using the inputs currently applied.
    task automatic monitor_cycle();
        if (reset) begin
            exp_pc    = 8'h00;
            halt_seen = 1'b0;
            stall_cnt = 0;
        end else if (redirect) begin
            exp_pc    = redirect_pc;
            halt_seen = 1'b0;
            stall_cnt = 0;
        end else if (halt_seen) begin
            check_eq("valid_after_halt", 32'(instr_valid), 32'd0);
            check_eq("halted_hold", 32'(halted), 32'd1);
        end else if (instr_valid) begin
            stall_cnt = 0;
            check_eq("head_pc", 32'(instr_pc), 32'(exp_pc));
            check_eq("head_instr", 32'(instr), 32'(rom[exp_pc]));
            if (instr_ready) begin
                accepts++;
                acc_pcs.push_back(instr_pc);
                if (instr[7:4] == 4'h0) begin
                    check_eq("halted_at_halt", 32'(halted), 32'd1);
                    halt_seen = 1'b1;
                end
                exp_pc = exp_pc + 8'd1;
            end
        end else begin
            stall_cnt++;
            if (stall_cnt == 6) check_eq("stall_timeout", 32'(instr_valid), 32'd1);
        end
    endtask

    task automatic tick();
        monitor_cycle();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        check_eq({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check_eq({tag, "_instr"}, 32'(instr), 32'd0);
        check_eq({tag, "_instr_pc"}, 32'(instr_pc), 32'd0);
        check_eq({tag, "_halted"}, 32'(halted), 32'd0);
    endtask

    initial begin
        int n0;
        vectors     = 0;
        miscompares = 0;
        accepts     = 0;
        stall_cnt   = 0;
        exp_pc      = 8'h00;
        halt_seen   = 1'b0;
        reset       = 1'b1;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        fill_rom(0);
        for (int i = 0; i < 6; i++) rom[i] = 8'h11 + 8'(i);
        @(negedge clk);

        // reset state, then first fetch latency and full-rate streaming
        tick();
        tick();
        check_reset_outputs("reset");
        reset       = 1'b0;
        instr_ready = 1'b1;
        check_eq("c0_rom_addr", 32'(rom_addr), 32'd0);
        tick();
        check_eq("c1_valid", 32'(instr_valid), 32'd0);
        tick();
        check_eq("c2_valid", 32'(instr_valid), 32'd1);
        check_eq("c2_pc", 32'(instr_pc), 32'd0);
        check_eq("c2_instr", 32'(instr), 32'h11);
        n0 = accepts;
        repeat (6) tick();
        check_eq("stream_rate", 32'(accepts - n0), 32'd6);

        // back-pressure: buffer fills to DEPTH, fetch stops, drains in order
        reset = 1'b1; instr_ready = 1'b0;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        check_eq("stall_rom_addr", 32'(rom_addr), 32'd4);
        check_eq("stall_valid", 32'(instr_valid), 32'd1);
        check_eq("stall_pc", 32'(instr_pc), 32'd0);
        n0 = accepts;
        instr_ready = 1'b1;
        repeat (8) tick();
        check_eq("release_rate", 32'(accepts - n0), 32'd8);

        // HALT at address 3
        reset = 1'b1; rom[3] = 8'h00;
        tick();
        reset = 1'b0;
        n0 = accepts;
        repeat (15) tick();
        check_eq("halt_accepts", 32'(accepts - n0), 32'd4);
        check_eq("halt_flag", 32'(halted), 32'd1);
        check_eq("halt_rom_addr", 32'(rom_addr), 32'd5);
        check_eq("halt_valid", 32'(instr_valid), 32'd0);
        redirect = 1'b1; redirect_pc = 8'h10;
        tick();
        redirect = 1'b0;
        check_eq("redirect_clears_halt", 32'(halted), 32'd0);
        repeat (4) tick();

        // redirect with a full-credit buffer and a response in flight
        reset = 1'b1; instr_ready = 1'b0; rom[3] = plain_word();
        tick();
        reset = 1'b0;
        repeat (4) tick();
        check_eq("pre_redir_rom_addr", 32'(rom_addr), 32'd4);
        check_eq("pre_redir_valid", 32'(instr_valid), 32'd1);
        redirect = 1'b1; redirect_pc = 8'h20; instr_ready = 1'b1;
        tick();
        redirect = 1'b0;
        check_eq("r1_valid", 32'(instr_valid), 32'd0);
        check_eq("r1_rom_addr", 32'(rom_addr), 32'h20);
        tick();
        check_eq("r2_valid", 32'(instr_valid), 32'd0);
        tick();
        check_eq("r3_valid", 32'(instr_valid), 32'd1);
        check_eq("r3_pc", 32'(instr_pc), 32'h20);
        repeat (4) tick();

        // redirect near the top of the address space wraps to 0
        redirect = 1'b1; redirect_pc = 8'hFE;
        tick();
        acc_pcs.delete();
        redirect = 1'b0;
        repeat (6) tick();
        check_eq("wrap_count_ok", 32'(acc_pcs.size() >= 4), 32'd1);
        if (acc_pcs.size() >= 4) begin
            check_eq("wrap_pc0", 32'(acc_pcs[0]), 32'hFE);
            check_eq("wrap_pc1", 32'(acc_pcs[1]), 32'hFF);
            check_eq("wrap_pc2", 32'(acc_pcs[2]), 32'h00);
            check_eq("wrap_pc3", 32'(acc_pcs[3]), 32'h01);
        end

        // one-cycle reset mid-stream with a partly filled buffer
        instr_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check_reset_outputs("midreset");
        reset = 1'b0; instr_ready = 1'b1;
        tick();
        tick();
        check_eq("midreset_valid", 32'(instr_valid), 32'd1);
        check_eq("midreset_pc", 32'(instr_pc), 32'd0);

        // random traffic: ready jitter, sporadic redirects, HALTs and resets
        reset = 1'b1;
        fill_rom(8);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            instr_ready = ($urandom_range(9, 0) < 7);
            redirect    = ($urandom_range(39, 0) == 0);
            redirect_pc = 8'($urandom);
            reset       = ($urandom_range(499, 0) == 0);
            tick();
        end
        reset = 1'b0; redirect = 1'b0;
        tick();
        check_eq("random_progress", 32'(accepts > 500), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
